muldiv: RTL

Iterative multiply/divide unit for the RISC-V M extension. It sits next to the single-cycle `alu` in the execute stage and handles the eight M-extension funct3 operations over `Width`-bit operands. It computes one bit per cycle and uses a valid/ready handshake on both the operand side and the result side. Divide-by-zero and signed overflow take a fast path, and a flush input lets the pipeline kill an in-flight operation.

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/isa.svh | 19 +
 rtl/muldiv_step.sv | 55 +++++
 rtl/muldiv.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- types and op-class helpers shared by the muldiv unit.
// Contents: FSM state enum, funct3 op type, and predicates that classify an
// M-extension funct3 (divide class, remainder, high product half, operand
// signedness).
`include "isa.svh"

package muldiv_pkg;

    localparam int OpW = `ISA__FUNCT3_WIDTH;

    typedef logic [OpW-1:0] op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // DIV, DIVU, REM, REMU
    function automatic logic is_div(input op_t op);
        return (op == `ISA__FUNCT3_DIV)  || (op == `ISA__FUNCT3_DIVU) ||
               (op == `ISA__FUNCT3_REM)  || (op == `ISA__FUNCT3_REMU);
    endfunction

    // REM, REMU
    function automatic logic is_rem(input op_t op);
        return (op == `ISA__FUNCT3_REM) || (op == `ISA__FUNCT3_REMU);
    endfunction

    // MULH, MULHSU, MULHU return the upper half of the product
    function automatic logic is_high(input op_t op);
        return (op == `ISA__FUNCT3_MULH) || (op == `ISA__FUNCT3_MULHSU) ||
               (op == `ISA__FUNCT3_MULHU);
    endfunction

    function automatic logic a_signed(input op_t op);
        return (op == `ISA__FUNCT3_MULH) || (op == `ISA__FUNCT3_MULHSU) ||
               (op == `ISA__FUNCT3_DIV)  || (op == `ISA__FUNCT3_REM);
    endfunction

    function automatic logic b_signed(input op_t op);
        return (op == `ISA__FUNCT3_MULH) || (op == `ISA__FUNCT3_DIV) ||
               (op == `ISA__FUNCT3_REM);
    endfunction

endpackage

// File: rtl/isa.svh
// isa.svh -- shared RISC-V ISA constants.
// Provides the default datapath width and the M-extension funct3 encodings
// used by the execute-stage units.
`ifndef ISA__SVH
`define ISA__SVH

`define ISA__XLEN          32
`define ISA__FUNCT3_WIDTH  3

`define ISA__FUNCT3_MUL    3'b000
`define ISA__FUNCT3_MULH   3'b001
`define ISA__FUNCT3_MULHSU 3'b010
`define ISA__FUNCT3_MULHU  3'b011
`define ISA__FUNCT3_DIV    3'b100
`define ISA__FUNCT3_DIVU   3'b101
`define ISA__FUNCT3_REM    3'b110
`define ISA__FUNCT3_REMU   3'b111

`endif

// File: rtl/muldiv_step.sv
// muldiv_step -- one combinational iteration of the iterative datapath.
// Multiply (div_i=0): shift-add. {hi,lo} is the partial product with the
//   remaining multiplier bits in the low end of lo; opnd_i is the multiplicand.
// Divide (div_i=1): restoring shift-subtract. hi is the partial remainder,
//   lo shifts dividend bits out the top and quotient bits in at the bottom;
//   opnd_i is the divisor.
// Macro CORE__MULDIV_DIV_EN: when undefined only the multiply step is built.
// Ports:
//   div_i        select divide step
//   hi_i, lo_i   current accumulator halves
//   opnd_i       multiplicand or divisor magnitude
//   hi_o, lo_o   accumulator halves after one iteration
module muldiv_step #(
    parameter int Width = 32
) (
    input  logic             div_i,
    input  logic [Width-1:0] hi_i,
    input  logic [Width-1:0] lo_i,
    input  logic [Width-1:0] opnd_i,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);

    logic [Width:0] sum;

`ifdef CORE__MULDIV_DIV_EN
    logic [Width:0] shifted;
    logic [Width:0] diff;
`else
    logic unused_div;
    assign unused_div = div_i;
`endif

    always_comb begin
        // The carry out of the add becomes the new top bit after the shift.
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        hi_o = sum[Width:1];
        lo_o = {sum[0], lo_i[Width-1:1]};
`ifdef CORE__MULDIV_DIV_EN
        shifted = {hi_i, lo_i[Width-1]};
        diff    = shifted - {1'b0, opnd_i};
        if (div_i) begin
            // diff[Width] set means the trial subtraction went negative: restore.
            if (!diff[Width]) begin
                hi_o = diff[Width-1:0];
                lo_o = {lo_i[Width-2:0], 1'b1};
            end else begin
                hi_o = shifted[Width-1:0];
                lo_o = {lo_i[Width-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/muldiv.sv
// muldiv -- iterative RISC-V M-extension multiply/divide unit, one bit/cycle.
// Macro CORE__MULDIV_DIV_EN: builds the divider and its fast path. Without it,
// DIV/DIVU/REM/REMU complete immediately with c=0 and illegal=1.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake (a, b, op)
//   flush                 synchronous kill of the in-flight/pending operation
//   out_valid/out_ready   result handshake (c, illegal)
//   dbg_state_o           current FSM state (muldiv_pkg::state_e encoding)
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid stays high with c/illegal
// stable until the out_ready edge, and in_ready rises the cycle after.
`include "isa.svh"

module muldiv
    import muldiv_pkg::*;
#(
    parameter int Width = `ISA__XLEN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [Width-1:0]              a,
    input  logic [Width-1:0]              b,
    input  logic [`ISA__FUNCT3_WIDTH-1:0] op,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [Width-1:0]              c,
    output logic                          illegal,
    output logic [1:0]                    dbg_state_o
);

    localparam int CntW = $clog2(Width);
    localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);
`ifdef CORE__MULDIV_DIV_EN
    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};
`endif

    state_e           state_q, state_d;
    op_t              op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] hi_q, hi_d;
    logic [Width-1:0] lo_q, lo_d;
    logic [Width-1:0] opnd_q, opnd_d;
    logic             neg_q, neg_d;
    logic [Width-1:0] c_q, c_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;

    // Accept-side operand conditioning
    logic             a_neg, b_neg, res_neg;
    logic [Width-1:0] a_mag, b_mag;

    logic [Width-1:0]   step_hi, step_lo;
    logic [2*Width-1:0] prod_full;
    logic [Width-1:0]   fix_res;
`ifdef CORE__MULDIV_DIV_EN
    logic [Width-1:0]   div_sel;
    logic               div_zero, div_ovf;
`endif

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign c           = c_q;
    assign illegal     = illegal_q;
    assign dbg_state_o = state_q;

    always_comb begin
        a_neg   = a_signed(op) & a[Width-1];
        b_neg   = b_signed(op) & b[Width-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        // Remainder follows the dividend's sign; product/quotient the xor.
        res_neg = is_rem(op) ? a_neg : (a_neg ^ b_neg);
`ifdef CORE__MULDIV_DIV_EN
        div_zero = (b == '0);
        div_ovf  = a_signed(op) && (a == MinVal) && (b == '1);
`endif
    end

    muldiv_step #(.Width(Width)) u_step (
        .div_i  (is_div(op_q)),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .opnd_i (opnd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    // Sign fix-up. A signed high product needs the full 2*Width negation so
    // the borrow from the low half reaches the upper half.
    always_comb begin
        prod_full = {hi_q, lo_q};
        if (neg_q) begin
            prod_full = -prod_full;
        end
        fix_res = is_high(op_q) ? prod_full[2*Width-1:Width] : prod_full[Width-1:0];
`ifdef CORE__MULDIV_DIV_EN
        div_sel = is_rem(op_q) ? hi_q : lo_q;
        if (is_div(op_q)) begin
            fix_res = neg_q ? -div_sel : div_sel;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        neg_d       = neg_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        illegal_d   = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    cnt_d = '0;
                    neg_d = res_neg;
                    hi_d  = '0;
                    if (is_div(op)) begin
`ifdef CORE__MULDIV_DIV_EN
                        lo_d   = a_mag;
                        opnd_d = b_mag;
                        if (div_zero) begin
                            state_d     = S_DONE;
                            out_valid_d = 1'b1;
                            illegal_d   = 1'b0;
                            c_d         = is_rem(op) ? a : '1;
                        end else if (div_ovf) begin
                            state_d     = S_DONE;
                            out_valid_d = 1'b1;
                            illegal_d   = 1'b0;
                            c_d         = is_rem(op) ? '0 : a;
                        end else begin
                            state_d = S_RUN;
                        end
`else
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        illegal_d   = 1'b1;
                        c_d         = '0;
`endif
                    end else begin
                        lo_d    = b_mag;
                        opnd_d  = a_mag;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == CntLast) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                c_d         = fix_res;
                illegal_d   = 1'b0;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over every transition, including an accept in IDLE;
        // the last delivered result stays on c.
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            c_d         = c_q;
            illegal_d   = illegal_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            neg_q       <= 1'b0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            neg_q       <= neg_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

endmodule
